mil_push_fifo: RTL and testbench

- Elastic word buffer between a MIL word producer (SPI-side decoder) and the transceiver push input.
- Accepts words via a request/done push handshake, stores up to DEPTH words in order, and replays them downstream with the same handshake.
- Decouples bursty SPI traffic from the slow line-rate transmitter.

---
 rtl/mil_push_fifo_pkg.sv | 28 ++
 rtl/mil_fifo_mem.sv | 28 ++
 rtl/mil_push_fifo.sv | 129 ++++++++++++
 tb/tb_mil_push_fifo.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mil_push_fifo_pkg.sv
// Shared MIL-STD-1553 word types, FIFO storage entry layout and output FSM states
// for the transceiver push FIFO.
package mil_push_fifo_pkg;

    typedef enum logic [1:0] {
        WSERV    = 2'd0,
        WDATA    = 2'd1,
        WSERVERR = 2'd2,
        WDATAERR = 2'd3
    } WordType;

    typedef struct packed {
        WordType     dataType;
        logic [15:0] dataWord;
    } MilWord;

    typedef enum logic [1:0] {
        OUT_IDLE,
        OUT_REQ,
        OUT_WAIT
    } out_state_t;

    // Words flagged by the decoder as corrupted
    function automatic logic is_err_type(input logic [1:0] word_type);
        return (word_type == WSERVERR) || (word_type == WDATAERR);
    endfunction

endpackage

// File: rtl/mil_fifo_mem.sv
// Single-clock register array for the push FIFO: one write port, one
// combinational read port, one MilWord per entry.
module mil_fifo_mem
    import mil_push_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int W  = $bits(MilWord)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mil_push_fifo.sv
// Elastic MIL word buffer between the SPI-side decoder and the transceiver push input.
// Optional MIL_FIFO_DROP_ERR_EN: discard error-typed words and count them in err_drop_cnt.
module mil_push_fifo
    import mil_push_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_request,
    input  logic [1:0]    in_type,
    input  logic [15:0]   in_data,
    output logic          in_done,
    output logic          out_request,
    output logic [1:0]    out_type,
    output logic [15:0]   out_data,
    input  logic          out_done,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full,
    output logic          overflow
`ifdef MIL_FIFO_DROP_ERR_EN
    ,
    output logic [15:0]   err_drop_cnt
`endif
);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [17:0]   rd_word;
    logic          is_err;
    logic          push_ok;
    logic          pop;
    MilWord        head_q;
    out_state_t    state;
    out_state_t    state_next;

`ifdef MIL_FIFO_DROP_ERR_EN
    assign is_err = is_err_type(in_type);
`else
    assign is_err = 1'b0;
`endif

    // Fullness is judged on the registered count, so a same-cycle pop never frees room for a push
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign push_ok = in_request && !full && !is_err;
    assign pop     = (state == OUT_WAIT) && out_done;

    mil_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr),
        .wdata ({in_type, in_data}),
        .raddr (rd_ptr),
        .rdata (rd_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            in_done  <= 1'b0;
        end else begin
            in_done <= in_request;
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (pop && !push_ok) begin
                count <= count - (AW+1)'(1);
            end
            if (in_request && full && !is_err) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef MIL_FIFO_DROP_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_drop_cnt <= '0;
        end else if (in_request && is_err && (err_drop_cnt != 16'hFFFF)) begin
            err_drop_cnt <= err_drop_cnt + 16'd1;
        end
    end
`endif

    // Head word is captured when the request is launched and held until the downstream completes
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '{dataType: WSERV, dataWord: 16'h0000};
        end else if ((state == OUT_IDLE) && !empty) begin
            head_q <= MilWord'(rd_word);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= OUT_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            OUT_IDLE: if (!empty)  state_next = OUT_REQ;
            OUT_REQ:               state_next = OUT_WAIT;
            OUT_WAIT: if (out_done) state_next = OUT_IDLE;
            default:               state_next = OUT_IDLE;
        endcase
    end

    always_comb begin
        out_request = (state == OUT_REQ);
        out_type    = head_q.dataType;
        out_data    = head_q.dataWord;
    end

endmodule

// File: tb/tb_mil_push_fifo.sv
// Directed self-checking bench for mil_push_fifo at DEPTH=4; a negedge monitor
// records every downstream request so emitted word order can be checked afterwards.
module tb_mil_push_fifo;
    import mil_push_fifo_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_request;
    logic [1:0]    in_type;
    logic [15:0]   in_data;
    logic          in_done;
    logic          out_request;
    logic [1:0]    out_type;
    logic [15:0]   out_data;
    logic          out_done;
    logic [AW:0]   count;
    logic          empty;
    logic          full;
    logic          overflow;
`ifdef MIL_FIFO_DROP_ERR_EN
    logic [15:0]   err_drop_cnt;
`endif

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          req_seen     = 0;
    int          base;
    logic [17:0] got_q [$];

    mil_push_fifo #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_request  (in_request),
        .in_type     (in_type),
        .in_data     (in_data),
        .in_done     (in_done),
        .out_request (out_request),
        .out_type    (out_type),
        .out_data    (out_data),
        .out_done    (out_done),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .overflow    (overflow)
`ifdef MIL_FIFO_DROP_ERR_EN
        ,
        .err_drop_cnt(err_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_request) begin
            got_q.push_back({out_type, out_data});
            req_seen++;
        end
    end

    task tick;
        @(posedge clk);
        #1;
    endtask

    task checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One-cycle push pulse; the acknowledge must follow in the very next cycle
    task applyStimulus(input logic [1:0] word_type, input logic [15:0] word);
        in_request = 1'b1;
        in_type    = word_type;
        in_data    = word;
        tick;
        in_request = 1'b0;
        checkOutput("in_done", {31'd0, in_done}, 32'd1);
    endtask

    task doDone;
        out_done = 1'b1;
        tick;
        out_done = 1'b0;
    endtask

    task doReset;
        rst        = 1'b1;
        in_request = 1'b0;
        out_done   = 1'b0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task waitRequest(input int target, input string tag);
        int n;
        n = 0;
        while (req_seen < target && n < 40) begin
            tick;
            n++;
        end
        checkOutput(tag, req_seen, target);
    endtask

    function automatic logic [17:0] gotAt(input int idx);
        if (idx < got_q.size()) return got_q[idx];
        return 18'h3FFFF;
    endfunction

    initial begin
        rst        = 1'b1;
        in_request = 1'b0;
        in_type    = 2'd0;
        in_data    = 16'h0000;
        out_done   = 1'b0;

        doReset;
        checkOutput("rst_count",    count,       0);
        checkOutput("rst_empty",    empty,       1);
        checkOutput("rst_full",     full,        0);
        checkOutput("rst_overflow", overflow,    0);
        checkOutput("rst_in_done",  in_done,     0);
        checkOutput("rst_out_req",  out_request, 0);
        checkOutput("rst_out_type", out_type,    0);
        checkOutput("rst_out_data", out_data,    0);

        // Single word: request two cycles after the push, data held across a slow completion
        applyStimulus(WDATA, 16'hA5A5);
        checkOutput("single_count1",  count,       1);
        checkOutput("single_noreq",   out_request, 0);
        tick;
        checkOutput("single_req",     out_request, 1);
        checkOutput("single_data",    out_data,    16'hA5A5);
        checkOutput("single_type",    out_type,    1);
        checkOutput("single_done_lo", in_done,     0);
        tick;
        checkOutput("single_pulse",   out_request, 0);
        repeat (8) tick;
        checkOutput("single_hold",    out_data,    16'hA5A5);
        doDone;
        checkOutput("single_count0",  count,       0);
        checkOutput("single_empty",   empty,       1);

        // Order and pointer wrap: six words through a four-deep buffer
        doReset;
        base = req_seen;
        applyStimulus(WDATA, 16'h0001);
        applyStimulus(WDATA, 16'h0002);
        applyStimulus(WDATA, 16'h0003);
        for (int i = 1; i <= 6; i++) begin
            waitRequest(base + i, "order_req");
            if (i + 3 <= 6) applyStimulus(WDATA, 16'(i + 3));
            doDone;
        end
        repeat (4) tick;
        checkOutput("order_nreq",  req_seen, base + 6);
        checkOutput("order_empty", empty,    1);
        checkOutput("order_ovf",   overflow, 0);
        for (int k = 0; k < 6; k++) begin
            checkOutput("order_word", gotAt(base + k), {2'b01, 16'(k + 1)});
        end

        // Overflow: fifth push is acknowledged but dropped
        doReset;
        base = req_seen;
        for (int k = 1; k <= 4; k++) applyStimulus(WDATA, 16'(16'h0010 + k));
        checkOutput("ovf_count4", count,    4);
        checkOutput("ovf_full",   full,     1);
        checkOutput("ovf_clear",  overflow, 0);
        applyStimulus(WDATA, 16'h0015);
        checkOutput("ovf_set",    overflow, 1);
        checkOutput("ovf_count",  count,    4);
        for (int k = 1; k <= 4; k++) begin
            waitRequest(base + k, "ovf_req");
            doDone;
        end
        repeat (6) tick;
        checkOutput("ovf_nreq",   req_seen, base + 4);
        checkOutput("ovf_empty",  empty,    1);
        checkOutput("ovf_sticky", overflow, 1);
        for (int k = 0; k < 4; k++) begin
            checkOutput("ovf_word", gotAt(base + k), {2'b01, 16'(16'h0011 + k)});
        end
        doReset;
        checkOutput("ovf_rst", overflow, 0);

        // Simultaneous push and pop at count 2
        base = req_seen;
        applyStimulus(WDATA, 16'h0A0A);
        applyStimulus(WDATA, 16'h0B0B);
        waitRequest(base + 1, "sim_req1");
        checkOutput("sim_count_pre", count, 2);
        in_request = 1'b1;
        in_type    = WDATA;
        in_data    = 16'h0C0C;
        out_done   = 1'b1;
        tick;
        in_request = 1'b0;
        out_done   = 1'b0;
        checkOutput("sim_count", count,   2);
        checkOutput("sim_ack",   in_done, 1);
        waitRequest(base + 2, "sim_req2");
        checkOutput("sim_word2", gotAt(base + 1), {2'b01, 16'h0B0B});
        doDone;
        waitRequest(base + 3, "sim_req3");
        checkOutput("sim_word3", gotAt(base + 2), {2'b01, 16'h0C0C});
        doDone;
        repeat (3) tick;
        checkOutput("sim_empty", empty, 1);

        // Simultaneous push and pop while full: the push is dropped
        doReset;
        base = req_seen;
        for (int k = 1; k <= 4; k++) applyStimulus(WDATA, 16'(16'h0020 + k));
        waitRequest(base + 1, "fsim_req1");
        in_request = 1'b1;
        in_type    = WDATA;
        in_data    = 16'h0025;
        out_done   = 1'b1;
        tick;
        in_request = 1'b0;
        out_done   = 1'b0;
        checkOutput("fsim_count", count,    3);
        checkOutput("fsim_ovf",   overflow, 1);
        checkOutput("fsim_ack",   in_done,  1);
        for (int k = 2; k <= 4; k++) begin
            waitRequest(base + k, "fsim_req");
            doDone;
        end
        repeat (6) tick;
        checkOutput("fsim_nreq",  req_seen, base + 4);
        checkOutput("fsim_empty", empty,    1);
        for (int k = 1; k < 4; k++) begin
            checkOutput("fsim_word", gotAt(base + k), {2'b01, 16'(16'h0021 + k)});
        end

        // Reset while waiting for completion, then a stray completion
        doReset;
        base = req_seen;
        applyStimulus(WDATA, 16'h0031);
        applyStimulus(WDATA, 16'h0032);
        waitRequest(base + 1, "rw_req");
        rst = 1'b1;
        tick;
        rst      = 1'b0;
        out_done = 1'b1;
        tick;
        out_done = 1'b0;
        checkOutput("rw_count",    count,       0);
        checkOutput("rw_empty",    empty,       1);
        checkOutput("rw_out_req",  out_request, 0);
        checkOutput("rw_out_type", out_type,    0);
        checkOutput("rw_out_data", out_data,    0);
        checkOutput("rw_in_done",  in_done,     0);
        repeat (5) tick;
        checkOutput("rw_nreq",     req_seen,    base + 1);
        checkOutput("rw_count2",   count,       0);

        // Error-typed words
        doReset;
        base = req_seen;
`ifdef MIL_FIFO_DROP_ERR_EN
        applyStimulus(WSERV,    16'h1234);
        applyStimulus(WDATAERR, 16'hDEAD);
        applyStimulus(WDATA,    16'h5678);
        waitRequest(base + 1, "err_req1");
        doDone;
        waitRequest(base + 2, "err_req2");
        doDone;
        repeat (6) tick;
        checkOutput("err_nreq",  req_seen,        base + 2);
        checkOutput("err_word1", gotAt(base),     {2'b00, 16'h1234});
        checkOutput("err_word2", gotAt(base + 1), {2'b01, 16'h5678});
        checkOutput("err_cnt",   err_drop_cnt,    1);
        checkOutput("err_empty", empty,           1);
`else
        applyStimulus(WDATAERR, 16'hDEAD);
        waitRequest(base + 1, "err_req");
        checkOutput("err_word", gotAt(base), {2'b11, 16'hDEAD});
        doDone;
        repeat (3) tick;
        checkOutput("err_empty", empty, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
